// File: rtl/adder_pipe_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : adder_arb_pkg
//  Brief   : Shared types, constants and helpers for the adder arbiter slice.
//  Revision: 1.0 - initial release
// ============================================================================
package adder_arb_pkg;

    // Bit width needed to index 'value' items, never less than one bit.
    function automatic int clog2_safe(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

    // Geometry of the shared adder instance, exported for benches.
    localparam int c_STAGE_WIDTH      = 128;
    localparam int c_IN_WIDTH_DEFAULT = 501;
    localparam int c_ADDER_LATENCY    =
        (c_IN_WIDTH_DEFAULT + c_STAGE_WIDTH - 1) / c_STAGE_WIDTH;

    // Requester index type, wide enough for the largest supported N_REQ.
    localparam int c_N_REQ_MAX = 8;
    localparam int c_ID_W      = clog2_safe(c_N_REQ_MAX);
    typedef logic [c_ID_W-1:0] id_t;

endpackage
`default_nettype wire

// File: rtl/adder_pipe_arbiter_tag_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : arb_tag_fifo
//  Brief   : Synchronous FIFO holding requester tags of in-flight additions.
//  Revision: 1.0 - initial release
// ============================================================================
module arb_tag_fifo
    import adder_arb_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 2
)(
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Overflowing pushes and underflowing pops are silently dropped.
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    assign full     = (r_count == (PTR_W+1)'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign pop_data = r_mem[r_rd_ptr];

    // Tag storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/adder_pipe_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : adder_pipe_arbiter
//  Brief   : Round-robin sharing of one pipelined wide adder between N_REQ
//            requesters, with in-order tag tracking and result routing.
//  Revision: 1.0 - initial release
// ============================================================================
module adder_pipe_arbiter
    import adder_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int IN_WIDTH  = 501,
    parameter int TAG_DEPTH = 16
)(
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*IN_WIDTH-1:0] req_a,
    input  logic [N_REQ*IN_WIDTH-1:0] req_b,
    input  logic [N_REQ-1:0]          req_cin,
    output logic                      add_in_valid,
    output logic [IN_WIDTH-1:0]       add_a,
    output logic [IN_WIDTH-1:0]       add_b,
    output logic                      add_cin,
    input  logic [IN_WIDTH-1:0]       add_s,
    input  logic                      add_cout,
    input  logic                      add_out_valid,
    output logic [N_REQ-1:0]          resp_valid,
    output logic [IN_WIDTH-1:0]       resp_s,
    output logic                      resp_cout,
    output logic                      busy,
    output logic                      err_orphan
);

    localparam int ID_W  = clog2_safe(N_REQ);
    localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     w_grant_idx;
    logic [ID_W-1:0]     w_cand;
    logic                w_grant_found;
    logic                w_can_issue;
    logic                w_accept;
    logic [N_REQ-1:0]    w_req_ready;
    logic [N_REQ-1:0]    w_resp_onehot;
    logic                w_pop;
    logic                w_orphan;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [CNT_W-1:0]    w_fifo_count;
    logic [ID_W-1:0]     w_fifo_head;

    logic                r_add_in_valid;
    logic [IN_WIDTH-1:0] r_add_a;
    logic [IN_WIDTH-1:0] r_add_b;
    logic                r_add_cin;
    logic [N_REQ-1:0]    r_resp_valid;
    logic [IN_WIDTH-1:0] r_resp_s;
    logic                r_resp_cout;
    logic                r_err_orphan;

    // The tag is pushed on the accepting edge, so an issue not yet seen by
    // the adder is already counted in the FIFO occupancy.
    assign w_can_issue = ~w_fifo_full;
    assign w_accept    = w_grant_found & w_can_issue;
    assign w_pop       = add_out_valid & (w_fifo_count != '0);
    assign w_orphan    = add_out_valid & (w_fifo_count == '0);

    // Round-robin search: first valid requester at or above the pointer, wrapping.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_cand        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = ID_W'((int'(r_rr_ptr) + k) % N_REQ);
            if (!w_grant_found && req_valid[w_cand]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_cand;
            end
        end
    end

    // Only the granted requester may see ready, and only when a tag slot is free.
    always_comb begin
        w_req_ready = '0;
        if (w_accept) begin
            w_req_ready[w_grant_idx] = 1'b1;
        end
    end

    // Decode the popped tag into the per-requester result strobe.
    always_comb begin
        w_resp_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_resp_onehot[i] = w_pop && (w_fifo_head == ID_W'(i));
        end
    end

    arb_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .WIDTH (ID_W)
    ) u_tag_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (w_accept),
        .push_data (w_grant_idx),
        .pop       (w_pop),
        .pop_data  (w_fifo_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    // Issue registers, pointer advance, result routing and sticky orphan flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rr_ptr       <= '0;
            r_add_in_valid <= 1'b0;
            r_add_a        <= '0;
            r_add_b        <= '0;
            r_add_cin      <= 1'b0;
            r_resp_valid   <= '0;
            r_resp_s       <= '0;
            r_resp_cout    <= 1'b0;
            r_err_orphan   <= 1'b0;
        end else begin
            r_add_in_valid <= w_accept;
            if (w_accept) begin
                r_add_a   <= req_a[int'(w_grant_idx)*IN_WIDTH +: IN_WIDTH];
                r_add_b   <= req_b[int'(w_grant_idx)*IN_WIDTH +: IN_WIDTH];
                r_add_cin <= req_cin[w_grant_idx];
                r_rr_ptr  <= (w_grant_idx == ID_W'(N_REQ-1)) ? '0 : w_grant_idx + 1'b1;
            end
            r_resp_valid <= w_resp_onehot;
            if (w_pop) begin
                r_resp_s    <= add_s;
                r_resp_cout <= add_cout;
            end
            if (w_orphan) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

    assign req_ready    = w_req_ready;
    assign add_in_valid = r_add_in_valid;
    assign add_a        = r_add_a;
    assign add_b        = r_add_b;
    assign add_cin      = r_add_cin;
    assign resp_valid   = r_resp_valid;
    assign resp_s       = r_resp_s;
    assign resp_cout    = r_resp_cout;
    assign busy         = ~w_fifo_empty | r_add_in_valid;
    assign err_orphan   = r_err_orphan;

endmodule
`default_nettype wire

// File: tb/tb_adder_pipe_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_adder_pipe_arbiter
//  Brief   : Directed self-checking bench for adder_pipe_arbiter, with a
//            4-stage adder model behind each arbiter instance.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_adder_pipe_arbiter;
    import adder_arb_pkg::*;

    localparam int N = 4;
    localparam int W = 501;
    localparam int L = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    // Main instance (TAG_DEPTH = 16)
    logic [N-1:0]   req_valid = '0, req_ready, req_cin = '0, resp_valid;
    logic [N*W-1:0] req_a = '0, req_b = '0;
    logic           add_in_valid, add_cin, add_cout, add_out_valid, resp_cout, busy, err_orphan;
    logic [W-1:0]   add_a, add_b, add_s, resp_s;
    logic           force_orphan = 1'b0;

    // Shallow-FIFO instance (TAG_DEPTH = 2)
    logic [N-1:0]   req_valid2 = '0, req_ready2, req_cin2 = '0, resp_valid2;
    logic [N*W-1:0] req_a2 = '0, req_b2 = '0;
    logic           add_in_valid2, add_cin2, add_cout2, add_out_valid2, resp_cout2, busy2, err_orphan2;
    logic [W-1:0]   add_a2, add_b2, add_s2, resp_s2;

    adder_pipe_arbiter #(.N_REQ(N), .IN_WIDTH(W), .TAG_DEPTH(16)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .add_in_valid(add_in_valid), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout), .add_out_valid(add_out_valid),
        .resp_valid(resp_valid), .resp_s(resp_s), .resp_cout(resp_cout),
        .busy(busy), .err_orphan(err_orphan)
    );

    adder_pipe_arbiter #(.N_REQ(N), .IN_WIDTH(W), .TAG_DEPTH(2)) dut2 (
        .clk(clk), .resetn(resetn), .req_valid(req_valid2), .req_ready(req_ready2),
        .req_a(req_a2), .req_b(req_b2), .req_cin(req_cin2),
        .add_in_valid(add_in_valid2), .add_a(add_a2), .add_b(add_b2), .add_cin(add_cin2),
        .add_s(add_s2), .add_cout(add_cout2), .add_out_valid(add_out_valid2),
        .resp_valid(resp_valid2), .resp_s(resp_s2), .resp_cout(resp_cout2),
        .busy(busy2), .err_orphan(err_orphan2)
    );

    // Adder models: L-stage pipelines, deliberately not reset.
    logic [L-1:0] m1_v = '0, m2_v = '0;
    logic [W:0]   m1_s [L];
    logic [W:0]   m2_s [L];

    always @(posedge clk) begin
        m1_v    <= {m1_v[L-2:0], add_in_valid};
        m1_s[0] <= {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
        m2_v    <= {m2_v[L-2:0], add_in_valid2};
        m2_s[0] <= {1'b0, add_a2} + {1'b0, add_b2} + {{W{1'b0}}, add_cin2};
        for (int i = 1; i < L; i++) begin
            m1_s[i] <= m1_s[i-1];
            m2_s[i] <= m2_s[i-1];
        end
    end

    assign add_out_valid  = m1_v[L-1] | force_orphan;
    assign add_s          = m1_s[L-1][W-1:0];
    assign add_cout       = m1_s[L-1][W];
    assign add_out_valid2 = m2_v[L-1];
    assign add_s2         = m2_s[L-1][W-1:0];
    assign add_cout2      = m2_s[L-1][W];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn     = 1'b0;
        req_valid  = '0;
        req_valid2 = '0;
        step();
        step();
        resetn = 1'b1;
    endtask

    typedef struct {
        int         id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic       cin;
        logic [W-1:0] s;
        logic       cout;
    } vec_t;

    // One isolated transaction: ready at accept, result exactly L+2 cycles later.
    task automatic run_vec(input vec_t v, input string nm);
        logic [N-1:0] oh;
        int cyc;
        oh = '0;
        oh[v.id] = 1'b1;
        req_a[v.id*W +: W] = v.a;
        req_b[v.id*W +: W] = v.b;
        req_cin[v.id]      = v.cin;
        req_valid          = oh;
        #1;
        chk({nm, " ready"}, req_ready, oh);
        step();
        req_valid = '0;
        cyc = 1;
        while (resp_valid == '0 && cyc < 20) begin
            step();
            cyc++;
        end
        chk({nm, " latency"}, cyc, L + 2);
        chk({nm, " resp_valid"}, resp_valid, oh);
        chk({nm, " resp_s"}, resp_s, v.s);
        chk({nm, " resp_cout"}, resp_cout, v.cout);
        step();
        chk({nm, " single strobe"}, resp_valid, 0);
    endtask

    vec_t         vecs[6];
    logic [W-1:0] ones;
    logic [W-1:0] top;
    vec_t         fresh;

    initial begin
        int nxt;
        int q[$];
        int exp_v;
        int id;

        ones = '1;
        top  = '0;
        top[W-1] = 1'b1;
        vecs[0] = '{2, 1, 2, 1'b0, 3, 1'b0};
        vecs[1] = '{0, ones, 0, 1'b1, 0, 1'b1};
        vecs[2] = '{1, ones, ones, 1'b1, ones, 1'b1};
        vecs[3] = '{3, 5, 7, 1'b1, 13, 1'b0};
        vecs[4] = '{0, top, top, 1'b0, 0, 1'b1};
        vecs[5] = '{1, 501'hFFFF_FFFF_FFFF_FFFF, 501'h1, 1'b1,
                    501'h1_0000_0000_0000_0001, 1'b0};

        // Reset state
        resetn = 1'b0;
        step();
        step();
        chk("rst req_ready", req_ready, 0);
        chk("rst add_in_valid", add_in_valid, 0);
        chk("rst add_a", add_a, 0);
        chk("rst add_b", add_b, 0);
        chk("rst add_cin", add_cin, 0);
        chk("rst resp_valid", resp_valid, 0);
        chk("rst resp_s", resp_s, 0);
        chk("rst resp_cout", resp_cout, 0);
        chk("rst busy", busy, 0);
        chk("rst err_orphan", err_orphan, 0);
        resetn = 1'b1;

        // Table-driven single transactions
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // All requesters valid: grants rotate 0,1,2,3 and results stream back-to-back
        do_reset();
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = W'(i + 1);
            req_b[i*W +: W] = W'(10 * i);
            req_cin[i]      = 1'b0;
        end
        for (int c = 0; c < 16; c++) begin
            req_valid = (c < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (c < 8) chk($sformatf("rr ready c%0d", c), req_ready, 4'b0001 << (c % 4));
            if (c >= 6 && c < 14) begin
                id = (c - 6) % 4;
                chk($sformatf("rr resp_valid c%0d", c), resp_valid, 4'b0001 << id);
                chk($sformatf("rr resp_s c%0d", c), resp_s, id + 1 + 10 * id);
            end else begin
                chk($sformatf("rr idle c%0d", c), resp_valid, 0);
            end
            step();
        end

        // TAG_DEPTH=2: ready stalls after two outstanding, results stay ordered
        nxt = 0;
        req_b2[0 +: W] = W'(100);
        for (int c = 0; c < 24; c++) begin
            req_valid2      = (c < 18) ? 4'b0001 : 4'b0000;
            req_a2[0 +: W]  = W'(nxt);
            #1;
            if (c < 18) chk($sformatf("depth ready c%0d", c), req_ready2,
                            ((c % 6) < 2) ? 4'b0001 : 4'b0000);
            if (req_valid2[0] && req_ready2[0]) begin
                q.push_back(nxt);
                nxt++;
            end
            if (resp_valid2 != '0) begin
                chk($sformatf("depth resp_valid c%0d", c), resp_valid2, 4'b0001);
                if (q.size() == 0) begin
                    chk("depth resp with nothing outstanding", 1, 0);
                end else begin
                    exp_v = q.pop_front();
                    chk($sformatf("depth resp_s c%0d", c), resp_s2, exp_v + 100);
                end
            end
            step();
        end
        chk("depth accepts", nxt, 6);
        chk("depth drained", q.size(), 0);

        // Reset with three results in flight
        do_reset();
        for (int k = 0; k < 3; k++) begin
            req_a[k*W +: W] = W'(k + 7);
            req_b[k*W +: W] = W'(1);
            req_valid = 4'b0001 << k;
            step();
        end
        req_valid = '0;
        chk("flight busy", busy, 1);
        resetn = 1'b0;
        step();
        chk("flight rst add_in_valid", add_in_valid, 0);
        chk("flight rst add_a", add_a, 0);
        chk("flight rst resp_valid", resp_valid, 0);
        chk("flight rst resp_s", resp_s, 0);
        chk("flight rst busy", busy, 0);
        chk("flight rst err_orphan", err_orphan, 0);
        resetn = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            chk($sformatf("flight stale resp c%0d", c), resp_valid, 0);
        end
        chk("flight err_orphan", err_orphan, 1);
        fresh = '{1, 40, 2, 1'b0, 42, 1'b0};
        run_vec(fresh, "post-reset");

        // Orphan pulse with empty FIFO, sticky through normal traffic
        do_reset();
        chk("orphan pre", err_orphan, 0);
        force_orphan = 1'b1;
        step();
        force_orphan = 1'b0;
        chk("orphan set", err_orphan, 1);
        chk("orphan no resp", resp_valid, 0);
        run_vec(vecs[0], "orphan traffic");
        chk("orphan sticky", err_orphan, 1);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        chk("orphan cleared", err_orphan, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
